// File: rtl/serial_byte_tx_pkg.sv
// Shared definitions for the serial frame transmitter, its matching receiver
// and their benches.
//   - state encoding (IDLE=0 .. STOP=4)
//   - frame_len(): total line cycles per frame for a given parameter set
package serial_byte_tx_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } state_t;

  // start + data + optional parity + stop bits
  function automatic int frame_len(input int data_w, input int parity_en,
                                   input int stop_bits);
    return 1 + data_w + parity_en + stop_bits;
  endfunction

endpackage

// File: rtl/serial_byte_tx_shift_reg.sv
// Loadable right-shift register holding the word being sent, plus the parity
// bit captured from the word at load time.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   load       : capture data and its parity
//   shift      : move the next data bit into bit0
//   data       : word to capture
//   bit0       : current data bit on the line (LSB first)
//   parity     : parity of the captured word
module tx_shift_reg
  import serial_byte_tx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PARITY_ODD = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] data,
  output logic              bit0,
  output logic              parity
);

  logic [DATA_W-1:0] sr;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr     <= '0;
      parity <= 1'b0;
    end else if (load) begin
      sr     <= data;
      parity <= (PARITY_ODD != 0) ? ~^data : ^data;
    end else if (shift) begin
      sr     <= sr >> 1;
    end
  end

  assign bit0 = sr[0];

endmodule

// File: rtl/serial_byte_tx.sv
// Serial frame transmitter: takes a word over valid/ready and sends
// start(0), DATA_W data bits LSB first, optional parity, STOP_BITS stop(1).
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   in_valid   : in_data is valid
//   in_data    : word to send
//   in_ready   : word accepted at this edge if in_valid
//   tx_out     : serial line, idles high
//   busy       : a frame is on the line
//   done       : pulse during the final stop bit
// All outputs decode from registered state only, so in_valid/in_data never
// reach an output combinationally.
module serial_byte_tx
  import serial_byte_tx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 1,
  parameter int STOP_BITS  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              done
);

  localparam int             CW        = $clog2(DATA_W + 1);
  localparam logic [CW-1:0]  LAST_BIT  = CW'(DATA_W - 1);
  localparam logic [1:0]     LAST_STOP = 2'(STOP_BITS - 1);

  state_t        state, state_nx;
  logic [CW-1:0] bit_cnt;
  logic [1:0]    stop_cnt;
  logic          accept, last_stop, sr_bit0, sr_parity;

  assign last_stop = (state == STOP) && (stop_cnt == LAST_STOP);
  // Ready in the last stop cycle lets frames run back to back with no gap.
  assign in_ready  = (state == IDLE) || last_stop;
  assign accept    = in_valid && in_ready;
  assign busy      = (state != IDLE);
  assign done      = last_stop;

  tx_shift_reg #(
    .DATA_W     (DATA_W),
    .PARITY_ODD (PARITY_ODD)
  ) u_sr (
    .clk    (clk),
    .reset  (reset),
    .load   (accept),
    .shift  (state == DATA),
    .data   (in_data),
    .bit0   (sr_bit0),
    .parity (sr_parity)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (accept) state_nx = START;
      START:  state_nx = DATA;
      DATA:   if (bit_cnt == LAST_BIT)
                state_nx = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY: state_nx = STOP;
      STOP:   if (stop_cnt == LAST_STOP)
                state_nx = accept ? START : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Counters restart on every state change, so each state counts from 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt  <= '0;
      stop_cnt <= '0;
    end else if (state_nx != state) begin
      bit_cnt  <= '0;
      stop_cnt <= '0;
    end else begin
      if (state == DATA) bit_cnt  <= bit_cnt + CW'(1);
      if (state == STOP) stop_cnt <= stop_cnt + 2'd1;
    end
  end

  always_comb begin
    tx_out = 1'b1;
    case (state)
      START:   tx_out = 1'b0;
      DATA:    tx_out = sr_bit0;
      PARITY:  tx_out = sr_parity;
      default: tx_out = 1'b1;
    endcase
  end

endmodule
